// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: one requester's request/response bundle into the arbiter
interface mem_port_arbiter_if #(parameter int DATA_W = 32);
  logic req;
  logic we;
  logic [31:0] addr;
  logic [DATA_W-1:0] wdata;
  logic ack;
  logic err;
  logic [DATA_W-1:0] rdata;
  modport master (output req, we, addr, wdata, input ack, err, rdata);
  modport slave (input req, we, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin sharing of one word-addressed memory between ports A and B
module mem_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_BITS = 16
) (
  input  logic clk,
  input  logic rst_n,
  mem_port_arbiter_if.slave a_if,
  mem_port_arbiter_if.slave b_if,
  output logic [31:0] mem_address_o,
  output logic [DATA_W-1:0] mem_data_in_o,
  output logic mem_read_o,
  output logic mem_write_o,
  input  logic [DATA_W-1:0] mem_data_out_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q;
  logic owner_b_q, last_b_q, we_q, err_q, rd_q, wr_q;
  logic a_ack_q, b_ack_q, a_err_q, b_err_q;
  logic [29:0] addr_q;
  logic [DATA_W-1:0] wdata_q, a_rdata_q, b_rdata_q;
  logic win_b, win_we, win_err;
  logic [31:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  // on a tie the port that did not win last time gets the grant
  assign win_b = b_if.req && (!a_if.req || !last_b_q);
  assign win_addr = win_b ? b_if.addr : a_if.addr;
  assign win_we = win_b ? b_if.we : a_if.we;
  assign win_wdata = win_b ? b_if.wdata : a_if.wdata;
  assign win_err = (|win_addr[1:0]) || ((win_addr >> (ADDR_BITS + 2)) != 32'd0);
  assign mem_address_o = {addr_q, 2'b00};
  assign mem_data_in_o = wdata_q;
  assign mem_read_o = rd_q;
  assign mem_write_o = wr_q;
  assign a_if.ack = a_ack_q;
  assign a_if.err = a_err_q;
  assign a_if.rdata = a_rdata_q;
  assign b_if.ack = b_ack_q;
  assign b_if.err = b_err_q;
  assign b_if.rdata = b_rdata_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_b_q <= 1'b0;
      last_b_q <= 1'b1;
      we_q <= 1'b0;
      err_q <= 1'b0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      a_err_q <= 1'b0;
      b_err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (a_if.req || b_if.req) begin
          state_q <= ACCESS;
          owner_b_q <= win_b;
          last_b_q <= win_b;
          addr_q <= win_addr[31:2];
          we_q <= win_we;
          wdata_q <= win_wdata;
          err_q <= win_err;
          rd_q <= !win_err && !win_we;
          wr_q <= !win_err && win_we;
        end
        ACCESS: begin
          state_q <= RESP;
          rd_q <= 1'b0;
          wr_q <= 1'b0;
          // errored accesses return zero data even for writes
          if (!owner_b_q && (err_q || !we_q)) a_rdata_q <= err_q ? '0 : mem_data_out_i;
          if (owner_b_q && (err_q || !we_q)) b_rdata_q <= err_q ? '0 : mem_data_out_i;
          a_ack_q <= !owner_b_q;
          b_ack_q <= owner_b_q;
          a_err_q <= !owner_b_q && err_q;
          b_err_q <= owner_b_q && err_q;
        end
        RESP: begin
          state_q <= IDLE;
          a_ack_q <= 1'b0;
          b_ack_q <= 1'b0;
          a_err_q <= 1'b0;
          b_err_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, corner sequences and random traffic vs a memory model
module tb_mem_port_arbiter;
  localparam int DW = 32;
  localparam int AB = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.DATA_W(DW)) a_if ();
  mem_port_arbiter_if #(.DATA_W(DW)) b_if ();
  logic [31:0] mem_address;
  logic [DW-1:0] mem_data_in, mem_data_out;
  logic mem_read, mem_write;
  mem_port_arbiter #(.DATA_W(DW), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst_n(rst_n), .a_if(a_if), .b_if(b_if),
    .mem_address_o(mem_address), .mem_data_in_o(mem_data_in),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .mem_data_out_i(mem_data_out)
  );
  logic [DW-1:0] mem [0:(1<<AB)-1] = '{default: '0};
  assign mem_data_out = mem[mem_address[AB+1:2]];
  always @(posedge clk) if (mem_write) mem[mem_address[AB+1:2]] <= mem_data_in;
  int n_vec = 0, n_bad = 0, wr_cyc = 0, rd_cyc = 0;
  always @(negedge clk) begin
    if (mem_write) wr_cyc++;
    if (mem_read) rd_cyc++;
  end
  logic [31:0] ref_mem [int unsigned];
  typedef struct {
    bit port;
    bit we;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit exp_err;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t vt [12];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a >> 2) ? ref_mem[a >> 2] : 32'h0;
  endfunction
  task automatic model(input bit we, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] held, output bit e, output logic [31:0] r);
    e = (a % 4 != 0) || (a >= (32'h1 << (AB + 2)));
    r = e ? 32'h0 : (we ? held : ref_rd(a));
    if (!e && we) ref_mem[a >> 2] = d;
  endtask
  task automatic set_req(input bit p, input bit r, input bit we, input logic [31:0] a, input logic [31:0] d);
    if (p) begin
      b_if.req = r; b_if.we = we; b_if.addr = a; b_if.wdata = d;
    end else begin
      a_if.req = r; a_if.we = we; a_if.addr = a; a_if.wdata = d;
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  task automatic txn(input bit p, input bit we, input logic [31:0] a, input logic [31:0] d,
                     output bit got, output logic e, output logic [31:0] rd);
    set_req(p, 1, we, a, d);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (p ? b_if.ack : a_if.ack) got = 1;
    end
    e = p ? b_if.err : a_if.err;
    rd = p ? b_if.rdata : a_if.rdata;
    set_req(p, 0, 0, 0, 0);
  endtask
  initial begin
    bit got, e, me;
    logic [31:0] rd, mr;
    int w0, r0, n, prev;
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    vt[0]  = '{1, 1, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0};
    vt[1]  = '{1, 0, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF};
    vt[2]  = '{0, 0, 32'h0000_0006, 32'h0, 1, 32'h0};
    vt[3]  = '{0, 0, 32'h0004_0000, 32'h0, 1, 32'h0};
    vt[4]  = '{0, 1, 32'h0000_0008, 32'h1234_5678, 0, 32'h0};
    vt[5]  = '{0, 0, 32'h0000_0008, 32'h0, 0, 32'h1234_5678};
    vt[6]  = '{1, 1, 32'h0003_FFFC, 32'hCAFE_F00D, 0, 32'hDEAD_BEEF};
    vt[7]  = '{1, 0, 32'h0003_FFFC, 32'h0, 0, 32'hCAFE_F00D};
    vt[8]  = '{1, 1, 32'h0000_0003, 32'h55, 1, 32'h0};
    vt[9]  = '{1, 0, 32'h0000_0010, 32'h0, 0, 32'hDEAD_BEEF};
    vt[10] = '{1, 1, 32'h0004_0004, 32'h1, 1, 32'h0};
    vt[11] = '{1, 0, 32'h0000_0000, 32'h0, 0, 32'h0};
    repeat (3) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outputs", {31'h0, |{a_if.ack, b_if.ack, a_if.err, b_if.err, a_if.rdata, b_if.rdata,
          mem_read, mem_write, mem_address, mem_data_in}}, 32'h0);
    end
    foreach (vt[i]) begin
      w0 = wr_cyc;
      r0 = rd_cyc;
      txn(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, got, e, rd);
      model(vt[i].we, vt[i].addr, vt[i].wdata, 32'h0, me, mr);
      chk($sformatf("vec%0d_ack", i), {31'h0, got}, 32'h1);
      chk($sformatf("vec%0d_err", i), {31'h0, e}, {31'h0, vt[i].exp_err});
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
      chk($sformatf("vec%0d_wr_cycles", i), wr_cyc - w0, {31'h0, vt[i].we && !vt[i].exp_err});
      chk($sformatf("vec%0d_rd_cycles", i), rd_cyc - r0, {31'h0, !vt[i].we && !vt[i].exp_err});
    end
    chk("a_rdata_held", a_if.rdata, 32'h1234_5678);
    do_reset();
    set_req(0, 1, 0, 32'h8, 0);
    set_req(1, 1, 0, 32'h10, 0);
    n = 0;
    prev = 0;
    for (int i = 0; i < 40 && n < 5; i++) begin
      @(negedge clk);
      if (a_if.ack || b_if.ack) begin
        chk($sformatf("rr_order%0d", n), {30'h0, a_if.ack, b_if.ack}, (n % 2 == 0) ? 32'h2 : 32'h1);
        if (n > 0) chk($sformatf("rr_gap%0d", n), i - prev, 32'd3);
        prev = i;
        n++;
        if (n == 4) set_req(1, 0, 0, 0, 0);
        if (n == 5) set_req(0, 0, 0, 0, 0);
      end
    end
    chk("rr_ack_count", n, 32'd5);
    set_req(0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0);
    txn(1, 1, 32'h20, 32'h1111_2222, got, e, rd);
    model(1, 32'h20, 32'h1111_2222, 32'h0, me, mr);
    chk("pre_write_ack", {31'h0, got}, 32'h1);
    set_req(1, 1, 1, 32'h20, 32'h9999_9999);
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      got = mem_write;
    end
    chk("write_access_seen", {31'h0, got}, 32'h1);
    rst_n = 0;
    #1;
    chk("reset_drops_write", {31'h0, mem_write}, 32'h0);
    set_req(1, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1;
    n = 0;
    repeat (6) begin
      @(negedge clk);
      if (b_if.ack) n++;
    end
    chk("no_ack_after_reset", n, 32'd0);
    txn(1, 0, 32'h20, 0, got, e, rd);
    chk("prior_contents", rd, 32'h1111_2222);
    chk("prior_contents_model", rd, ref_rd(32'h20));
    begin
      bit pend [2];
      bit op_we [2];
      logic [31:0] op_a [2], op_d [2], exp_r [2], word;
      bit last, w, ex;
      do_reset();
      pend = '{0, 0};
      exp_r = '{32'h0, 32'h0};
      last = 1;
      for (int r = 0; r < 80; r++) begin
        for (int p = 0; p < 2; p++) begin
          if (!pend[p] && $urandom_range(1, 0) == 1) begin
            pend[p] = 1;
            word = $urandom_range(15, 0);
            op_we[p] = $urandom_range(1, 0) == 1;
            op_d[p] = $urandom;
            op_a[p] = ($urandom_range(7, 0) != 0) ? word * 4 :
                      ($urandom_range(1, 0) == 1) ? word * 4 + $urandom_range(3, 1) : 32'h0004_0000 + word * 4;
            set_req(p[0], 1, op_we[p], op_a[p], op_d[p]);
          end
        end
        if (!pend[0] && !pend[1]) begin
          pend[0] = 1;
          op_we[0] = 0;
          op_a[0] = 32'h10;
          op_d[0] = 0;
          set_req(0, 1, 0, 32'h10, 0);
        end
        w = (pend[0] && pend[1]) ? !last : pend[1];
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
          @(negedge clk);
          got = a_if.ack || b_if.ack;
        end
        chk("rnd_ack_seen", {31'h0, got}, 32'h1);
        if (!got) break;
        chk("rnd_winner", {30'h0, a_if.ack, b_if.ack}, {30'h0, !w, w});
        model(op_we[w], op_a[w], op_d[w], exp_r[w], ex, exp_r[w]);
        chk("rnd_err", {31'h0, w ? b_if.err : a_if.err}, {31'h0, ex});
        chk("rnd_rdata", w ? b_if.rdata : a_if.rdata, exp_r[w]);
        chk("rnd_other_rdata", w ? a_if.rdata : b_if.rdata, exp_r[!w]);
        last = w;
        pend[w] = 0;
        set_req(w, 0, 0, 0, 0);
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
